register_memory_arbiter: RTL and testbench
==========================================

# register_memory_arbiter

Shares the single read port of `register_memory` between up to `NUM_REQ` requesters, such as the accelerometer config sequencer and the 7-segment display formatter. Requesters are granted in round-robin order, one transaction at a time. The arbiter drives the memory address and waits a fixed read latency. It returns data and the error code to the granted requester, and rejects out-of-range addresses itself without touching memory.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 8: register address width.
- `DATA_W`, 32: register data width.
- `MEMORY_SIZE`, 255: number of valid addresses, 0..MEMORY_SIZE-1.
- `READ_LATENCY`, 1: clocks from `mem_addr` change to valid `mem_data`/`mem_error`, 1..4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; resets all state.
- `req_valid`  in  NUM_REQ  per-requester read request.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_ready`  out  NUM_REQ  one-hot accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle response strobe.
- `rsp_data`  out  DATA_W  response data, shared and qualified by `rsp_valid`.
- `rsp_error`  out  4  response error code, shared.
- `mem_addr`  out  ADDR_W  to `register_memory.reg_addr`.
- `mem_data`  in  DATA_W  from `register_memory.reg_data`.
- `mem_error`  in  4  from `register_memory.error_code`.

## Operation
FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, the round-robin picker selects g: the first set bit at or after `rr_ptr`, wrapping.
  - `req_ready[g]` is high combinationally in this cycle; all other ready bits are low.
  - On the edge, the arbiter latches g and `req_addr[g]`.
  - If addr < MEMORY_SIZE: `mem_addr` <= addr, `wait_cnt` <= READ_LATENCY-1, next state WAIT.
  - Otherwise: `rsp_data` <= 0, `rsp_error` <= 4'hE, `mem_addr` unchanged, next state RESP.
- **WAIT:**
  - While `wait_cnt` != 0, decrement it.
  - When `wait_cnt` == 0: `rsp_data` <= `mem_data`, `rsp_error` <= `mem_error`, next state RESP.
- **RESP:**
  - `rsp_valid[g]` is high for exactly this cycle.
  - `rr_ptr` <= (g+1) mod NUM_REQ; next state IDLE.
- `req_ready` is 0 outside IDLE. New requests are never accepted in WAIT or RESP.
- Requester rules:
  - Hold `req_valid` and `req_addr` stable until accepted.
  - Deasserting before acceptance is legal and leaves no trace.
  - A requester may re-request in the cycle after its `rsp_valid`.
- `mem_addr` holds its last value between transactions; the memory sees no spurious address changes.
- `rsp_data`/`rsp_error` hold their last values after RESP. They are meaningful only while `rsp_valid` is high.

## Timing
- Reset (`reset`=0, asynchronous):
  - State IDLE, `rr_ptr` 0, `wait_cnt` 0.
  - `mem_addr` 0, `rsp_data` 0, `rsp_error` 0, `rsp_valid` 0, `req_ready` 0.
  - An in-flight transaction is discarded with no response.
  - Release is synchronous to `clk`, supplied by `system_reset_controller`.
- Handshake in cycle T, valid address: `mem_addr` updates at T+1; `rsp_valid` at T+1+READ_LATENCY.
- Handshake in cycle T, out-of-range address: `rsp_valid` at T+1.
- Back-to-back throughput: the next handshake can occur in the cycle after RESP. Period is READ_LATENCY+2 cycles for valid addresses and 2 cycles for out-of-range.
- Simultaneous requests: exactly one is accepted per IDLE cycle. With all requesters held active, grants rotate 0,1,2,3,0,...
- Boundaries:
  - Address MEMORY_SIZE-1 is valid.
  - Address MEMORY_SIZE and above are rejected.
  - `rr_ptr` wraps from NUM_REQ-1 to 0.

## Structure
- Package `register_memory_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - `ERR_OUT_OF_RANGE` = 4'hE.
  - FSM enum `arb_state_t` {IDLE, WAIT, RESP}.
- Sub-module `rr_picker`:
  - Combinational; inputs `req` vector and `ptr`.
  - Outputs `gnt_onehot`, `gnt_idx`, `any`.
- `register_memory_arbiter` contains the FSM, latches, wait counter and response muxing.

## Test plan
Bench setup: `READ_LATENCY`=1, `NUM_REQ`=4, stub memory returning `mem_data` = 32'hA5A5_0000 | addr and `mem_error` = 0.
- **Single request:** `req_valid`=4'b0010, addr 8'h10, accepted at T. Expect `mem_addr`=8'h10 at T+1, then `rsp_valid`=4'b0010 with `rsp_data`=32'hA5A5_0010 and `rsp_error`=0 at T+2.
- **All four requesting continuously:** grant order is 0,1,2,3,0, with one `rsp_valid` every 3 cycles.
- **Out-of-range address:** addr 8'hFF (MEMORY_SIZE=255) from requester 2. Expect `rsp_valid`=4'b0100 at T+1 with `rsp_data`=0 and `rsp_error`=4'hE; `mem_addr` unchanged. Addr 8'hFE returns 32'hA5A5_00FE.
- **Reset in WAIT:** pull `reset` low in WAIT. Expect all outputs 0 immediately, no `rsp_valid` after release, and the next grant going to requester 0.
- **Error pass-through:** stub forces `mem_error`=4'h3. Expect `rsp_error`=4'h3 on the response.
- **Requester drops early:** requester 1 raises `req_valid` while busy and lowers it before IDLE. Expect no `req_ready[1]` and no response.

Source files
------------

// File: rtl/register_memory_pkg.sv
// Shared types and constants for the register_memory read-port arbiter.
package register_memory_pkg;

   localparam int DEFAULT_ADDR_W = 8;
   localparam int DEFAULT_DATA_W = 32;

   localparam logic [3:0] ERR_OUT_OF_RANGE = 4'hE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] size);
      return addr < size;
   endfunction

endpackage

// File: rtl/register_memory_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_picker
   import register_memory_pkg::*;
#(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt_onehot,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             any
);

   logic [PTR_W-1:0] cand_idx [N];
   logic [N-1:0]     cand_hit;

   // cand_idx[gi] is the requester gi positions after ptr in rotation order
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cand
         logic [PTR_W:0] sum;
         assign sum           = {1'b0, ptr} + (PTR_W+1)'(gi);
         assign cand_idx[gi]  = (sum >= (PTR_W+1)'(N)) ? PTR_W'(sum - (PTR_W+1)'(N))
                                                       : sum[PTR_W-1:0];
         assign cand_hit[gi]  = req[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            gnt_idx = cand_idx[k];
            any     = 1'b1;
         end
      end
   end

   assign gnt_onehot = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/register_memory_arbiter.sv
// Round-robin arbiter sharing the register_memory read port; rejects
// out-of-range addresses locally and waits a fixed latency for in-range reads.
module register_memory_arbiter
   import register_memory_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = DEFAULT_ADDR_W,
   parameter int DATA_W       = DEFAULT_DATA_W,
   parameter int MEMORY_SIZE  = 255,
   parameter int READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [3:0]                rsp_error,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_data,
   input  logic [3:0]                mem_error
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(READ_LATENCY - 1);

   arb_state_t        state_reg, state_next;
   logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [PTR_W-1:0]  gnt_reg, gnt_next;
   logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
   logic [3:0]        rsp_error_reg, rsp_error_next;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_any;
   logic [ADDR_W-1:0]  req_addr_arr [NUM_REQ];
   logic [ADDR_W-1:0]  sel_addr;
   logic               sel_in_range;

   rr_picker #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr_picker (
      .req        (req_valid),
      .ptr        (rr_ptr_reg),
      .gnt_onehot (pick_onehot),
      .gnt_idx    (pick_idx),
      .any        (pick_any)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign req_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         // ready is forced low while reset is held so nothing can handshake
         assign req_ready[gi]    = reset && (state_reg == IDLE) && pick_onehot[gi];
         assign rsp_valid[gi]    = (state_reg == RESP) && (gnt_reg == PTR_W'(gi));
      end
   endgenerate

   assign sel_addr     = req_addr_arr[pick_idx];
   assign sel_in_range = addr_in_range(32'(sel_addr), 32'(MEMORY_SIZE));

   always_comb begin
      state_next     = state_reg;
      rr_ptr_next    = rr_ptr_reg;
      gnt_next       = gnt_reg;
      wait_cnt_next  = wait_cnt_reg;
      mem_addr_next  = mem_addr_reg;
      rsp_data_next  = rsp_data_reg;
      rsp_error_next = rsp_error_reg;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               gnt_next = pick_idx;
               if (sel_in_range) begin
                  mem_addr_next = sel_addr;
                  wait_cnt_next = WAIT_INIT;
                  state_next    = WAIT;
               end else begin
                  rsp_data_next  = '0;
                  rsp_error_next = ERR_OUT_OF_RANGE;
                  state_next     = RESP;
               end
            end
         end
         WAIT: begin
            if (wait_cnt_reg != '0) begin
               wait_cnt_next = wait_cnt_reg - CNT_W'(1);
            end else begin
               rsp_data_next  = mem_data;
               rsp_error_next = mem_error;
               state_next     = RESP;
            end
         end
         RESP: begin
            rr_ptr_next = (gnt_reg == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_reg + PTR_W'(1);
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         gnt_reg       <= '0;
         wait_cnt_reg  <= '0;
         mem_addr_reg  <= '0;
         rsp_data_reg  <= '0;
         rsp_error_reg <= '0;
      end else begin
         state_reg     <= state_next;
         rr_ptr_reg    <= rr_ptr_next;
         gnt_reg       <= gnt_next;
         wait_cnt_reg  <= wait_cnt_next;
         mem_addr_reg  <= mem_addr_next;
         rsp_data_reg  <= rsp_data_next;
         rsp_error_reg <= rsp_error_next;
      end
   end

   assign mem_addr  = mem_addr_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_error = rsp_error_reg;

endmodule

// File: tb/tb_register_memory_arbiter.sv
// Scoreboard bench for register_memory_arbiter with a combinational stub memory.
module tb_register_memory_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int ADDR_W       = 8;
   localparam int DATA_W       = 32;
   localparam int MEMORY_SIZE  = 255;
   localparam int READ_LATENCY = 1;

   typedef struct {
      logic [3:0]  onehot;
      logic [31:0] data;
      logic [3:0]  err;
      int          due;
   } exp_t;

   logic                      clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [ADDR_W-1:0]         addr_v [NUM_REQ];
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic [3:0]                rsp_error;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_data;
   logic [3:0]                mem_error;
   logic [3:0]                err_force;

   exp_t        sb_q [$];
   int          n_checks   = 0;
   int          n_errors   = 0;
   int          cyc        = 0;
   int          m_ptr      = 0;
   int          m_free     = 0;
   logic [7:0]  m_mem_addr = 8'h00;

   assign req_addr  = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};
   assign mem_data  = 32'hA5A5_0000 | {24'h0, mem_addr};
   assign mem_error = err_force;

   register_memory_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .MEMORY_SIZE  (MEMORY_SIZE),
      .READ_LATENCY (READ_LATENCY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_error (rsp_error),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_error (mem_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      check_eq({tag, "_rsp_data"},  rsp_data,       32'h0);
      check_eq({tag, "_rsp_error"}, 32'(rsp_error), 32'h0);
      check_eq({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
   endtask

   // Model: predicts grants in idle cycles, pushes expected responses, pops on output.
   initial begin
      int         g;
      int         idx;
      exp_t       e;
      logic [7:0] a;
      logic [3:0] exp_ready;
      forever begin
         @(negedge clk);
         if (!reset) begin
            sb_q.delete();
            m_ptr      = 0;
            m_free     = 0;
            m_mem_addr = 8'h00;
            check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check_eq("rst_req_ready", 32'(req_ready), 32'h0);
         end else begin
            check_eq("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
            if (rsp_valid != '0 || (sb_q.size() > 0 && sb_q[0].due == cyc)) begin
               if (sb_q.size() == 0) begin
                  check_eq("rsp_spurious", 32'(rsp_valid), 32'h0);
               end else begin
                  e = sb_q.pop_front();
                  $display("rsp cycle=%0d valid=%b data=%h err=%h", cyc, rsp_valid, rsp_data, rsp_error);
                  check_eq("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
                  check_eq("rsp_cycle", 32'(cyc),       32'(e.due));
                  check_eq("rsp_data",  rsp_data,       e.data);
                  check_eq("rsp_error", 32'(rsp_error), 32'(e.err));
               end
            end
            if (cyc >= m_free) begin
               g = -1;
               for (int k = NUM_REQ - 1; k >= 0; k--) begin
                  idx = (m_ptr + k) % NUM_REQ;
                  if (req_valid[idx]) g = idx;
               end
               exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
               check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
               if (g >= 0) begin
                  a        = addr_v[g];
                  e.onehot = 4'b0001 << g;
                  if (int'(a) < MEMORY_SIZE) begin
                     e.data     = 32'hA5A5_0000 | {24'h0, a};
                     e.err      = err_force;
                     e.due      = cyc + 1 + READ_LATENCY;
                     m_mem_addr = a;
                  end else begin
                     e.data = 32'h0;
                     e.err  = 4'hE;
                     e.due  = cyc + 1;
                  end
                  m_free = e.due + 1;
                  m_ptr  = (g + 1) % NUM_REQ;
                  sb_q.push_back(e);
               end
            end else begin
               check_eq("req_ready_busy", 32'(req_ready), 32'h0);
            end
         end
      end
   end

   task automatic do_req(input int idx, input logic [7:0] a);
      int ok;
      ok          = 0;
      addr_v[idx] = a;
      req_valid[idx] = 1'b1;
      for (int n = 0; n < 50 && ok == 0; n++) begin
         @(negedge clk);
         if (req_ready[idx]) ok = 1;
      end
      check_eq("accept_timeout", 32'(ok), 32'h1);
      @(posedge clk);
      #1 req_valid[idx] = 1'b0;
   endtask

   task automatic wait_quiet();
      for (int n = 0; n < 50; n++) begin
         if (sb_q.size() == 0 && cyc >= m_free) break;
         @(posedge clk);
         #1;
      end
      check_eq("quiet_timeout", 32'(sb_q.size()), 32'h0);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      err_force = 4'h0;
      for (int i = 0; i < NUM_REQ; i++) addr_v[i] = 8'h00;
      #2 reset = 1'b0;
      #1 check_outputs_zero("por");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      do_req(1, 8'h10);
      wait_quiet();

      do_req(2, 8'hFF);
      do_req(2, 8'hFE);
      wait_quiet();

      err_force = 4'h3;
      do_req(3, 8'h20);
      wait_quiet();
      err_force = 4'h0;

      for (int i = 0; i < NUM_REQ; i++) addr_v[i] = 8'h40 + 8'(i);
      req_valid = 4'hF;
      repeat (13) @(posedge clk);
      #1 req_valid = '0;
      wait_quiet();

      do_req(0, 8'h30);
      addr_v[1]    = 8'h31;
      req_valid[1] = 1'b1;
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      wait_quiet();

      do_req(2, 8'h50);
      reset = 1'b0;
      #1 check_outputs_zero("rst_wait");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      addr_v[0] = 8'h60;
      addr_v[1] = 8'h61;
      addr_v[3] = 8'h63;
      req_valid = 4'b1011;
      repeat (9) @(posedge clk);
      #1 req_valid = '0;
      wait_quiet();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
